// File: rtl/lc3b_decode_stage_if.sv
//------------------------------------------------------------------------------
// Module      : lc3b_decode_stage_if
// Description : Fetch-side and execute-side handshake bundle for the LC-3b
//               decode stage. The slave modport is the decode stage itself;
//               the master modport is whatever drives it.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface lc3b_decode_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_ir;
    logic [15:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [9:0]  out_ctrl;
    logic [15:0] out_ir;
    logic [15:0] out_pc;
    logic [2:0]  out_sr1;
    logic [2:0]  out_sr2;
    logic [2:0]  out_dr;

    modport slave (
        input  in_valid, in_ir, in_pc, flush, out_ready,
        output in_ready, out_valid, out_ctrl, out_ir, out_pc,
               out_sr1, out_sr2, out_dr
    );

    modport master (
        output in_valid, in_ir, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_ctrl, out_ir, out_pc,
               out_sr1, out_sr2, out_dr
    );
endinterface

`default_nettype wire

// File: rtl/lc3b_decode_stage.sv
//------------------------------------------------------------------------------
// Module      : lc3b_decode_stage
// Description : LC-3b decode stage. Decodes each accepted instruction word into
//               a control word {opcode, aluop, load_cc, load_regfile} plus
//               register specifiers and holds it in a 2-entry skid buffer
//               (main entry drives the outputs, skid entry absorbs one stall).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lc3b_decode_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input wire                    clk,
    input wire                    reset_n,
    lc3b_decode_stage_if.slave    bus
);

    // Opcodes
    localparam logic [3:0] c_OP_BR   = 4'h0;
    localparam logic [3:0] c_OP_ADD  = 4'h1;
    localparam logic [3:0] c_OP_LDB  = 4'h2;
    localparam logic [3:0] c_OP_STB  = 4'h3;
    localparam logic [3:0] c_OP_JSR  = 4'h4;
    localparam logic [3:0] c_OP_AND  = 4'h5;
    localparam logic [3:0] c_OP_LDR  = 4'h6;
    localparam logic [3:0] c_OP_STR  = 4'h7;
    localparam logic [3:0] c_OP_NOT  = 4'h9;
    localparam logic [3:0] c_OP_LDI  = 4'hA;
    localparam logic [3:0] c_OP_STI  = 4'hB;
    localparam logic [3:0] c_OP_SHF  = 4'hD;
    localparam logic [3:0] c_OP_LEA  = 4'hE;

    // ALU operation encodings carried in the control word
    localparam logic [3:0] c_ALU_ADD  = 4'd0;
    localparam logic [3:0] c_ALU_AND  = 4'd1;
    localparam logic [3:0] c_ALU_NOT  = 4'd2;
    localparam logic [3:0] c_ALU_PASS = 4'd3;
    localparam logic [3:0] c_ALU_SLL  = 4'd4;
    localparam logic [3:0] c_ALU_SRL  = 4'd5;
    localparam logic [3:0] c_ALU_SRA  = 4'd6;

    typedef struct packed {
        logic [9:0]  ctrl;
        logic [15:0] ir;
        logic [15:0] pc;
        logic [2:0]  sr1;
        logic [2:0]  sr2;
        logic [2:0]  dr;
    } entry_t;

    // Occupancy of the skid buffer; FULL means the skid entry is in use
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic       r_in_ready;
    entry_t     r_m;
    entry_t     r_s;
    entry_t     w_dec;
    logic [3:0] w_opcode;
    logic [3:0] w_aluop;
    logic       w_load_cc;
    logic       w_load_rf;
    logic       w_in_fire;
    logic       w_out_fire;
    logic       w_load_m;
    logic       w_load_s;
    logic       w_m_from_s;

    assign w_opcode = bus.in_ir[15:12];

    // Combinational decode of the incoming word into a buffer entry
    always_comb begin
        w_aluop   = c_ALU_PASS;
        w_load_cc = 1'b0;
        case (w_opcode)
            c_OP_ADD: begin w_aluop = c_ALU_ADD; w_load_cc = 1'b1; end
            c_OP_AND: begin w_aluop = c_ALU_AND; w_load_cc = 1'b1; end
            c_OP_NOT: begin w_aluop = c_ALU_NOT; w_load_cc = 1'b1; end
            c_OP_SHF: begin
                w_load_cc = 1'b1;
                case (bus.in_ir[5:4])
                    2'b01:   w_aluop = c_ALU_SRL;
                    2'b11:   w_aluop = c_ALU_SRA;
                    default: w_aluop = c_ALU_SLL;
                endcase
            end
            c_OP_LDB, c_OP_LDI, c_OP_LDR, c_OP_LEA: w_load_cc = 1'b1;
            default: ;
        endcase
        w_load_rf = w_load_cc | (w_opcode == c_OP_JSR);

        w_dec      = '0;
        w_dec.ctrl = {w_opcode, w_aluop, w_load_cc, w_load_rf};
        w_dec.ir   = bus.in_ir;
        w_dec.pc   = bus.in_pc;
        w_dec.sr1  = bus.in_ir[8:6];
        // Stores read their data register through the second source port
        w_dec.sr2  = ((w_opcode == c_OP_STR) || (w_opcode == c_OP_STB) ||
                      (w_opcode == c_OP_STI)) ? bus.in_ir[11:9] : bus.in_ir[2:0];
        // JSR links into R7
        w_dec.dr   = (w_opcode == c_OP_JSR) ? 3'd7 : bus.in_ir[11:9];
    end

    assign w_in_fire  = bus.in_valid & r_in_ready;
    assign w_out_fire = (r_state != ST_EMPTY) & bus.out_ready;

    // Next occupancy and entry-move controls; flush overrides everything
    always_comb begin
        w_state_next = r_state;
        w_load_m     = 1'b0;
        w_load_s     = 1'b0;
        w_m_from_s   = 1'b0;
        if (bus.flush) begin
            w_state_next = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        w_state_next = ST_ONE;
                        w_load_m     = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        w_load_m = 1'b1;
                    end else if (w_in_fire) begin
                        w_state_next = ST_FULL;
                        w_load_s     = 1'b1;
                    end else if (w_out_fire) begin
                        w_state_next = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_out_fire) begin
                        w_state_next = ST_ONE;
                        w_m_from_s   = 1'b1;
                    end
                end
                default: w_state_next = ST_EMPTY;
            endcase
        end
    end

    // Occupancy register; in_ready is registered so it never depends on out_ready
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_in_ready <= (w_state_next != ST_FULL);
        end
    end

    // Main and skid entry storage
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_m <= '0;
            r_s <= '0;
        end else begin
            if (w_load_m) begin
                r_m <= w_dec;
            end else if (w_m_from_s) begin
                r_m <= r_s;
            end
            if (w_load_s) begin
                r_s <= w_dec;
            end
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = (r_state != ST_EMPTY);

    // Main entry drives the outputs; idle values whenever nothing is held
    always_comb begin
        if (r_state != ST_EMPTY) begin
            bus.out_ctrl = r_m.ctrl;
            bus.out_ir   = r_m.ir;
            bus.out_pc   = r_m.pc;
            bus.out_sr1  = r_m.sr1;
            bus.out_sr2  = r_m.sr2;
            bus.out_dr   = r_m.dr;
        end else begin
            bus.out_ctrl = '0;
            bus.out_ir   = '0;
            bus.out_pc   = RESET_PC;
            bus.out_sr1  = '0;
            bus.out_sr2  = '0;
            bus.out_dr   = '0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lc3b_decode_stage.sv
//------------------------------------------------------------------------------
// Module      : tb_lc3b_decode_stage
// Description : Self-checking bench for lc3b_decode_stage: fixed decode
//               vectors, directed stall/flush/reset sequences and a random
//               phase checked against a queue-based reference model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_lc3b_decode_stage;

    localparam logic [15:0] RESET_PC = 16'h1234;
    localparam logic [15:0] CC_MASK    = 16'h6666;  // ADD LDB AND LDR NOT LDI SHF LEA
    localparam logic [15:0] STORE_MASK = 16'h0888;  // STB STR STI

    typedef struct packed {
        logic [9:0]  ctrl;
        logic [15:0] ir;
        logic [15:0] pc;
        logic [2:0]  sr1;
        logic [2:0]  sr2;
        logic [2:0]  dr;
    } item_t;

    typedef struct {
        logic [15:0] ir;
        logic [15:0] pc;
        logic [9:0]  ctrl;
        logic [2:0]  sr1;
        logic [2:0]  sr2;
        logic [2:0]  dr;
    } vec_t;

    logic clk;
    logic reset_n;
    int   n_vec;
    int   n_bad;
    item_t q[$];
    logic [3:0] shf_alu [4];

    lc3b_decode_stage_if bus();

    lc3b_decode_stage #(.RESET_PC(RESET_PC)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic item_t ref_decode(input logic [15:0] ir, input logic [15:0] pc);
        item_t it;
        logic [3:0] op;
        logic [3:0] alu;
        logic cc;
        logic rf;
        op  = ir[15:12];
        cc  = CC_MASK[op];
        rf  = cc | (op == 4'd4);
        alu = (op == 4'd1) ? 4'd0 :
              (op == 4'd5) ? 4'd1 :
              (op == 4'd9) ? 4'd2 :
              (op == 4'd13) ? shf_alu[ir[5:4]] : 4'd3;
        it.ctrl = {op, alu, cc, rf};
        it.ir   = ir;
        it.pc   = pc;
        it.sr1  = ir[8:6];
        it.sr2  = STORE_MASK[op] ? ir[11:9] : ir[2:0];
        it.dr   = (op == 4'd4) ? 3'd7 : ir[11:9];
        return it;
    endfunction

    // Called at a negedge with inputs already driven: compare, then advance model
    task automatic cycle();
        item_t got;
        logic in_fire;
        logic out_fire;
        got = {bus.out_ctrl, bus.out_ir, bus.out_pc, bus.out_sr1, bus.out_sr2, bus.out_dr};
        chk("out_valid", 64'(bus.out_valid), 64'(q.size() > 0));
        chk("in_ready", 64'(bus.in_ready), 64'(q.size() < 2));
        if (q.size() > 0) chk("out_entry", 64'(got), 64'(q[0]));
        else              chk("idle_pc", 64'(bus.out_pc), 64'(RESET_PC));
        in_fire  = bus.in_valid && (q.size() < 2);
        out_fire = bus.out_ready && (q.size() > 0);
        @(posedge clk);
        if (bus.flush) begin
            q.delete();
        end else begin
            if (out_fire) void'(q.pop_front());
            if (in_fire)  q.push_back(ref_decode(bus.in_ir, bus.in_pc));
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        q.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    vec_t vecs[10];

    initial begin
        n_vec = 0;
        n_bad = 0;
        shf_alu = '{4'd4, 4'd5, 4'd4, 4'd6};
        vecs[0] = '{16'h1283, 16'h3002, 10'h043, 3'd2, 3'd3, 3'd1};
        vecs[1] = '{16'h4802, 16'h3004, 10'h10D, 3'd0, 3'd2, 3'd7};
        vecs[2] = '{16'h7A85, 16'h3006, 10'h1CC, 3'd2, 3'd5, 3'd5};
        vecs[3] = '{16'hD270, 16'h3008, 10'h35B, 3'd1, 3'd0, 3'd1};
        vecs[4] = '{16'h0000, 16'h300A, 10'h00C, 3'd0, 3'd0, 3'd0};
        vecs[5] = '{16'h5A3F, 16'h300C, 10'h147, 3'd0, 3'd7, 3'd5};
        vecs[6] = '{16'h96BF, 16'h300E, 10'h24B, 3'd2, 3'd7, 3'd3};
        vecs[7] = '{16'hD2A1, 16'h3010, 10'h353, 3'd2, 3'd1, 3'd1};
        vecs[8] = '{16'hE5FF, 16'h3012, 10'h38F, 3'd7, 3'd7, 3'd2};
        vecs[9] = '{16'h3C41, 16'h3014, 10'h0CC, 3'd1, 3'd6, 3'd6};

        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_ir     = '0;
        bus.in_pc     = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        #12;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_pc", 64'(bus.out_pc), 64'(RESET_PC));
        chk("rst_out_ctrl", 64'(bus.out_ctrl), 64'd0);
        chk("rst_out_regs", 64'({bus.out_ir, bus.out_sr1, bus.out_sr2, bus.out_dr}), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("ready_after_rst", 64'(bus.in_ready), 64'd1);

        // Fixed decode vectors, one instruction at a time
        for (int i = 0; i < 10; i++) begin
            bus.in_valid  = 1'b1;
            bus.in_ir     = vecs[i].ir;
            bus.in_pc     = vecs[i].pc;
            bus.out_ready = 1'b1;
            cycle();
            bus.in_valid = 1'b0;
            chk("vec_valid", 64'(bus.out_valid), 64'd1);
            chk("vec_ctrl", 64'(bus.out_ctrl), 64'(vecs[i].ctrl));
            chk("vec_regs", 64'({bus.out_sr1, bus.out_sr2, bus.out_dr}),
                64'({vecs[i].sr1, vecs[i].sr2, vecs[i].dr}));
            chk("vec_irpc", 64'({bus.out_ir, bus.out_pc}), 64'({vecs[i].ir, vecs[i].pc}));
            cycle();
        end

        // Back-to-back stream of 8 with downstream always ready
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = 1'b1;
            bus.in_ir    = 16'($urandom);
            bus.in_pc    = 16'h4000 + 16'(2 * i);
            cycle();
        end
        bus.in_valid = 1'b0;
        repeat (2) cycle();

        // Stall: three offered, two held, third waits for out_ready
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_ir    = 16'h1000 + 16'(i);
            bus.in_pc    = 16'h5000 + 16'(2 * i);
            if (i == 2) begin
                chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
                cycle();
                cycle();
                bus.out_ready = 1'b1;
                cycle();   // S moves to M; third still waiting
            end
            cycle();
        end
        bus.in_valid = 1'b0;
        repeat (4) cycle();

        // Flush while FULL with an input offered
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_ir     = 16'h1111; bus.in_pc = 16'h6000; cycle();
        bus.in_ir     = 16'h5222; bus.in_pc = 16'h6002; cycle();
        bus.in_ir     = 16'h9333; bus.in_pc = 16'h6004;
        bus.flush     = 1'b1;
        cycle();
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
        chk("flush_in_ready", 64'(bus.in_ready), 64'd1);
        bus.out_ready = 1'b1;
        repeat (3) cycle();

        // Asynchronous reset between clock edges
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_ir     = 16'h1283; bus.in_pc = 16'h7000;
        cycle();
        bus.in_valid = 1'b0;
        chk("pre_rst_valid", 64'(bus.out_valid), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_valid", 64'(bus.out_valid), 64'd0);
        chk("async_pc", 64'(bus.out_pc), 64'(RESET_PC));
        chk("async_ctrl", 64'(bus.out_ctrl), 64'd0);
        chk("async_regs", 64'({bus.out_ir, bus.out_sr1, bus.out_sr2, bus.out_dr}), 64'd0);
        @(negedge clk);
        do_reset();

        // Random traffic against the queue model
        for (int i = 0; i < 600; i++) begin
            bus.in_valid  = ($urandom_range(0, 9) < 7);
            bus.out_ready = ($urandom_range(0, 9) < 6);
            bus.flush     = ($urandom_range(0, 99) < 3);
            bus.in_ir     = 16'($urandom);
            bus.in_pc     = 16'($urandom);
            cycle();
        end
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
